// File: rtl/vga_sync_rx.sv
// VGA sync receiver: recovers pixel coordinates from active-low hsync/vsync,
// measures line/frame lengths and locks once the timing matches the parameters.
module vga_sync_rx #(
   parameter int unsigned H_PW        = 96,
   parameter int unsigned H_BP        = 48,
   parameter int unsigned H_DISP      = 640,
   parameter int unsigned H_FP        = 16,
   parameter int unsigned V_PW        = 2,
   parameter int unsigned V_BP        = 33,
   parameter int unsigned V_DISP      = 480,
   parameter int unsigned V_FP        = 10,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pix_en,
   input  logic        hsync,
   input  logic        vsync,
   output logic [10:0] x,
   output logic [10:0] y,
   output logic        active,
   output logic        locked,
   output logic [10:0] h_total,
   output logic [10:0] v_total
);

   localparam logic [10:0] H_S    = 11'(H_PW + H_BP + H_DISP + H_FP);
   localparam logic [10:0] V_S    = 11'(V_PW + V_BP + V_DISP + V_FP);
   localparam logic [10:0] H_OFF  = 11'(H_PW + H_BP);
   localparam logic [10:0] V_OFF  = 11'(V_PW + V_BP);
   localparam logic [10:0] H_ACT  = 11'(H_DISP);
   localparam logic [10:0] V_ACT  = 11'(V_DISP);
   localparam logic [10:0] H_PW_W = 11'(H_PW);
   localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);
   localparam logic [10:0] C_MAX  = '1;

   typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

   state_t      state;
   logic        hs_q;
   logic        vs_line;
   logic [10:0] h_cnt;
   logic [10:0] v_cnt;
   logic [10:0] hpw;
   logic [3:0]  good;
   logic        frame_ok;

   logic        hs_fall, vs_fall, line_ok, frame_len_ok, in_disp, overflow;
   logic [10:0] h_inc, v_inc, h_cnt_nx, v_cnt_nx, hpw_nx, x_nx, y_nx;

   always_comb begin
      hs_fall      = hs_q & ~hsync;
      vs_fall      = hs_fall & ~vsync & vs_line;
      h_inc        = (h_cnt == C_MAX) ? C_MAX : h_cnt + 11'd1;
      v_inc        = (v_cnt == C_MAX) ? C_MAX : v_cnt + 11'd1;
      line_ok      = (h_cnt + 11'd1 == H_S) && (hpw == H_PW_W);
      frame_len_ok = (v_cnt + 11'd1 == V_S);
      h_cnt_nx     = hs_fall ? '0 : h_inc;
      v_cnt_nx     = vs_fall ? '0 : (hs_fall ? v_inc : v_cnt);
      // the falling sample itself is the first pulse sample of the new line
      hpw_nx       = hs_fall ? 11'd1 : ((!hsync && hpw != C_MAX) ? hpw + 11'd1 : hpw);
      x_nx         = h_cnt_nx - H_OFF;
      y_nx         = v_cnt_nx - V_OFF;
      in_disp      = (x_nx < H_ACT) && (y_nx < V_ACT);
      overflow     = (h_cnt_nx == C_MAX) || (v_cnt_nx == C_MAX);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= SEARCH;
         hs_q     <= 1'b1;
         vs_line  <= 1'b1;
         h_cnt    <= '0;
         v_cnt    <= '0;
         hpw      <= '0;
         good     <= '0;
         frame_ok <= 1'b0;
         x        <= '0;
         y        <= '0;
         active   <= 1'b0;
         locked   <= 1'b0;
         h_total  <= '0;
         v_total  <= '0;
      end else if (pix_en) begin
         hs_q  <= hsync;
         h_cnt <= h_cnt_nx;
         v_cnt <= v_cnt_nx;
         hpw   <= hpw_nx;
         x     <= x_nx;
         y     <= y_nx;
         if (hs_fall) begin
            vs_line <= vsync;
            h_total <= h_cnt + 11'd1;
         end
         if (vs_fall) v_total <= v_cnt + 11'd1;
         if (vs_fall)                 frame_ok <= 1'b1;
         else if (hs_fall && !line_ok) frame_ok <= 1'b0;

         // locked/active are registered from the next state so they line up with x/y
         if (overflow) begin
            state  <= SEARCH;
            good   <= '0;
            locked <= 1'b0;
            active <= 1'b0;
         end else begin
            case (state)
               SEARCH: begin
                  locked <= 1'b0;
                  active <= 1'b0;
                  if (vs_fall) begin
                     state <= TRACK;
                     good  <= '0;
                  end
               end
               TRACK: begin
                  locked <= 1'b0;
                  active <= 1'b0;
                  if (vs_fall) begin
                     if (frame_ok && line_ok && frame_len_ok) begin
                        good <= good + 4'd1;
                        if (good + 4'd1 == LOCK_N) begin
                           state  <= LOCKED;
                           locked <= 1'b1;
                           active <= in_disp;
                        end
                     end else begin
                        good <= '0;
                     end
                  end
               end
               LOCKED: begin
                  if ((hs_fall && !line_ok) || (vs_fall && !frame_len_ok)) begin
                     state  <= TRACK;
                     good   <= '0;
                     locked <= 1'b0;
                     active <= 1'b0;
                  end else begin
                     locked <= 1'b1;
                     active <= in_disp;
                  end
               end
               default: begin
                  state  <= SEARCH;
                  good   <= '0;
                  locked <= 1'b0;
                  active <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
